// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams message words, appends 0x80 marker, zero fill and
// 64-bit bit length, and writes 16-word blocks to the scheduler memory. Build option:
// SHA256_PAD_BSWAP_EN selects little-endian input words (byte-swapped on entry).
module sha256_msg_padder #(
    parameter int MSG_LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [2:0]  s_bytes,
    output logic [31:0] message_word_in,
    output logic [3:0]  message_word_addr,
    output logic        write_enable_in,
    output logic        block_valid,
    output logic        block_last,
    input  logic        block_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PAD    = 3'd2,
        ZERO   = 3'd3,
        LEN_HI = 3'd4,
        LEN_LO = 3'd5,
        WAIT   = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [3:0]             word_idx_r;
    logic [MSG_LEN_W-1:0]   bit_len_r;
    logic [63:0]            len64_s;
    logic [31:0]            data_s;
    logic [31:0]            word_s;
    logic                   wr_s;
    logic                   accept_s;
    logic                   blk_pend_s;
    logic                   gen_go_s;
    logic [5:0]             len_inc_s;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Keep the first nbytes bytes and place the 0x80 marker right after them.
    function automatic logic [31:0] pad_merge(input logic [31:0] w, input logic [2:0] nbytes);
        logic [4:0]  sh;
        logic [31:0] keep;
        sh   = {nbytes[1:0], 3'b000};
        keep = ~(32'hFFFF_FFFF >> sh);
        if (nbytes[2]) begin
            pad_merge = w;
        end else begin
            pad_merge = (w & keep) | (32'h8000_0000 >> sh);
        end
    endfunction

`ifdef SHA256_PAD_BSWAP_EN
    assign data_s = byte_swap(s_data);
`else
    assign data_s = s_data;
`endif

    // A write to index 15 still in flight blocks any further write until the block is acked.
    assign blk_pend_s = write_enable_in && (message_word_addr == 4'd15);
    assign gen_go_s   = !block_valid && !blk_pend_s;
    assign s_ready    = !reset && ((state_r == IDLE) || (state_r == DATA)) && gen_go_s;
    assign accept_s   = s_valid && s_ready;
    assign len64_s    = 64'(bit_len_r);
    assign len_inc_s  = s_last ? {s_bytes, 3'b000} : 6'd32;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DATA: begin
                if (accept_s) begin
                    if (s_last) begin
                        next_state_s = s_bytes[2] ? PAD : ZERO;
                    end else begin
                        next_state_s = DATA;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            PAD:    next_state_s = gen_go_s ? ZERO : PAD;
            ZERO:   next_state_s = (gen_go_s && (word_idx_r == 4'd14)) ? LEN_HI : ZERO;
            LEN_HI: next_state_s = gen_go_s ? LEN_LO : LEN_HI;
            LEN_LO: next_state_s = gen_go_s ? WAIT : LEN_LO;
            WAIT:   next_state_s = (block_valid && block_ack) ? IDLE : WAIT;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: which word (if any) is written next cycle.
    always_comb begin
        wr_s   = 1'b0;
        word_s = 32'h0000_0000;
        case (state_r)
            IDLE, DATA: begin
                if (accept_s) begin
                    wr_s   = 1'b1;
                    word_s = s_last ? pad_merge(data_s, s_bytes) : data_s;
                end else begin
                    wr_s   = 1'b0;
                end
            end
            PAD: begin
                wr_s   = gen_go_s;
                word_s = 32'h8000_0000;
            end
            ZERO: begin
                wr_s   = gen_go_s && (word_idx_r != 4'd14);
                word_s = 32'h0000_0000;
            end
            LEN_HI: begin
                wr_s   = gen_go_s;
                word_s = len64_s[63:32];
            end
            LEN_LO: begin
                wr_s   = gen_go_s;
                word_s = len64_s[31:0];
            end
            default: begin
                wr_s   = 1'b0;
                word_s = 32'h0000_0000;
            end
        endcase
    end

    // Registered memory port, word index, length counter and block flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            message_word_in   <= 32'h0000_0000;
            message_word_addr <= 4'd0;
            write_enable_in   <= 1'b0;
            word_idx_r        <= 4'd0;
            bit_len_r         <= {MSG_LEN_W{1'b0}};
            block_valid       <= 1'b0;
            block_last        <= 1'b0;
        end else begin
            write_enable_in <= wr_s;
            if (wr_s) begin
                message_word_in   <= word_s;
                message_word_addr <= word_idx_r;
                word_idx_r        <= word_idx_r + 4'd1;
            end
            if ((state_r == WAIT) && (next_state_s == IDLE)) begin
                bit_len_r <= {MSG_LEN_W{1'b0}};
            end else if (accept_s) begin
                bit_len_r <= bit_len_r + MSG_LEN_W'(len_inc_s);
            end
            if (blk_pend_s) begin
                block_valid <= 1'b1;
                block_last  <= (state_r == WAIT);
            end else if (block_ack) begin
                block_valid <= 1'b0;
                block_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: random messages compared against a
// byte-level SHA-256 padding model; honours SHA256_PAD_BSWAP_EN when defined.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic [31:0] message_word_in;
    logic [3:0]  message_word_addr;
    logic        write_enable_in;
    logic        block_valid;
    logic        block_last;
    logic        block_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  msg[$];
    logic [31:0] exp_w[$];
    int          exp_blocks;
    logic [35:0] wr_q[$];
    logic        last_q[$];
    int viol = 0, resume_bad = 0, acks = 0, ack_dly = 0, ack_cnt = 0, beats_left = 0;
    logic prev_bv = 1'b0, prev_bl = 1'b0;

    always #5 clk = ~clk;

    sha256_msg_padder #(.MSG_LEN_W(64)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
        .message_word_in(message_word_in), .message_word_addr(message_word_addr),
        .write_enable_in(write_enable_in), .block_valid(block_valid),
        .block_last(block_last), .block_ack(block_ack)
    );

    // Monitor: log writes and block flags, flag protocol violations, drive block_ack.
    always @(negedge clk) begin
        if (write_enable_in) wr_q.push_back({message_word_addr, message_word_in});
        if (write_enable_in && block_valid) viol++;
        if (block_valid && s_ready) viol++;
        if (block_last && !block_valid) viol++;
        if (block_valid && !prev_bv) last_q.push_back(block_last);
        if (prev_bv && !block_valid && !prev_bl && beats_left > 0 && !s_ready) resume_bad++;
        prev_bv = block_valid;
        prev_bl = block_last;
        if (reset) begin
            block_ack = 1'b0;
            ack_cnt   = 0;
        end else if (block_ack) begin
            block_ack = 1'b0;
            ack_cnt   = 0;
            acks++;
        end else if (block_valid) begin
            if (ack_cnt >= ack_dly) block_ack = 1'b1;
            else ack_cnt++;
        end
    end

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Reference: pad the byte string per SHA-256 and split into big-endian words.
    task automatic build_expect();
        logic [7:0]  p[$];
        logic [63:0] bl;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        exp_w.delete();
        for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        exp_blocks = p.size() / 64;
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drive msg as beats; wait for all blocks to be acked unless stopped early.
    task automatic send(input bit zero_tail, input bit gaps, input int max_beats, input int dly,
                        output int wbase, output int lbase);
        logic [31:0] bw[$];
        logic [2:0]  bb[$];
        logic        bl[$];
        logic [31:0] w;
        int n, nf, lb, cnt, ack0;
        bit got, timeout;
        build_expect();
        n     = msg.size();
        wbase = wr_q.size();
        lbase = last_q.size();
        ack0  = acks;
        ack_dly = dly;
        nf = ((n % 4) == 0 && n > 0 && !zero_tail) ? (n / 4) - 1 : n / 4;
        lb = ((n % 4) == 0 && n > 0 && !zero_tail) ? 4 : n % 4;
        for (int i = 0; i < nf; i++) begin
            bw.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
            bb.push_back(3'($urandom_range(0, 7)));
            bl.push_back(1'b0);
        end
        w = $urandom;
        for (int k = 0; k < lb; k++) w[31-8*k -: 8] = msg[4*nf+k];
        bw.push_back(w);
        bb.push_back(3'(lb));
        bl.push_back(1'b1);
        cnt = (max_beats < bw.size()) ? max_beats : bw.size();
        beats_left = cnt;
        timeout = 1'b0;
        for (int i = 0; i < cnt && !timeout; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
`ifdef SHA256_PAD_BSWAP_EN
            s_data  = swap32(bw[i]);
`else
            s_data  = bw[i];
`endif
            s_last  = bl[i];
            s_bytes = bb[i];
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                #1;
                got = s_ready;
                @(posedge clk);
                if (!got) @(negedge clk);
            end
            beats_left--;
            if (!got) timeout = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!timeout && cnt == bw.size()) begin
            for (int c = 0; c < 3000 && acks < ack0 + exp_blocks; c++) @(negedge clk);
            if (acks < ack0 + exp_blocks) timeout = 1'b1;
            repeat (2) @(negedge clk);
        end
        beats_left = 0;
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL send_timeout got acks=%0d want %0d", acks - ack0, exp_blocks);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; s_bytes = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({message_word_in, message_word_addr, write_enable_in, block_valid, block_last, s_ready} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {message_word_in, message_word_addr, write_enable_in, block_valid, block_last, s_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", s_ready); end
    endtask

    task automatic test_abc();
        int wb, lb;
        msg = {8'h61, 8'h62, 8'h63};
        send(1'b0, 1'b0, 1000, 2, wb, lb);
        checks++;
        if (wr_q.size() - wb !== 16) begin errors++; $display("FAIL abc_count got %0d want 16", wr_q.size() - wb); end
        for (int i = 0; i < exp_w.size() && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb+i] !== {4'(i % 16), exp_w[i]}) begin
                errors++; $display("FAIL abc_word[%0d] got %h want %h", i, wr_q[wb+i], {4'(i % 16), exp_w[i]});
            end
        end
        checks++;
        if (wr_q.size() < wb + 16 || wr_q[wb][31:0] !== 32'h6162_6380 || wr_q[wb+15][31:0] !== 32'h0000_0018) begin
            errors++; $display("FAIL abc_const got size %0d want words 61626380/00000018", wr_q.size() - wb);
        end
        checks++;
        if (last_q.size() - lb !== 1 || last_q[lb] !== 1'b1) begin
            errors++; $display("FAIL abc_last got %0d blocks want 1 final", last_q.size() - lb);
        end
    endtask

    task automatic test_empty();
        int wb, lb;
        msg.delete();
        send(1'b0, 1'b0, 1000, 0, wb, lb);
        checks++;
        if (wr_q.size() - wb !== 16 || wr_q[wb] !== {4'd0, 32'h8000_0000}) begin
            errors++; $display("FAIL empty_first got %0d words want 16 with 80000000 first", wr_q.size() - wb);
        end
        for (int i = 1; i < 16 && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb+i] !== {4'(i), 32'h0}) begin
                errors++; $display("FAIL empty_word[%0d] got %h want %h", i, wr_q[wb+i], {4'(i), 32'h0});
            end
        end
        checks++;
        if (last_q.size() - lb !== 1 || last_q[lb] !== 1'b1) begin
            errors++; $display("FAIL empty_last got %0d blocks want 1 final", last_q.size() - lb);
        end
    endtask

    task automatic test_56_bytes();
        int wb, lb;
        rand_msg(56);
        send(1'b0, 1'b0, 1000, 1, wb, lb);
        checks++;
        if (wr_q.size() - wb !== 32) begin errors++; $display("FAIL b56_count got %0d want 32", wr_q.size() - wb); end
        for (int i = 0; i < exp_w.size() && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb+i] !== {4'(i % 16), exp_w[i]}) begin
                errors++; $display("FAIL b56_word[%0d] got %h want %h", i, wr_q[wb+i], {4'(i % 16), exp_w[i]});
            end
        end
        checks++;
        if (wr_q.size() < wb + 32 || wr_q[wb+14][31:0] !== 32'h8000_0000 || wr_q[wb+31][31:0] !== 32'h0000_01C0) begin
            errors++; $display("FAIL b56_const got size %0d want marker@14 and 000001C0@31", wr_q.size() - wb);
        end
        checks++;
        if (last_q.size() - lb !== 2 || last_q[lb] !== 1'b0 || last_q[lb+1] !== 1'b1) begin
            errors++; $display("FAIL b56_last got %0d blocks want 2 (last=0,1)", last_q.size() - lb);
        end
    endtask

    task automatic test_backpressure();
        int wb, lb, v0, r0;
        v0 = viol; r0 = resume_bad;
        rand_msg(80);
        send(1'b0, 1'b0, 1000, 10, wb, lb);
        checks++;
        if (wr_q.size() - wb !== exp_w.size()) begin
            errors++; $display("FAIL bp_count got %0d want %0d", wr_q.size() - wb, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb+i] !== {4'(i % 16), exp_w[i]}) begin
                errors++; $display("FAIL bp_word[%0d] got %h want %h", i, wr_q[wb+i], {4'(i % 16), exp_w[i]});
            end
        end
        checks++;
        if (viol - v0 !== 0) begin errors++; $display("FAIL bp_protocol got %0d violations want 0", viol - v0); end
        checks++;
        if (resume_bad - r0 !== 0) begin errors++; $display("FAIL bp_resume got %0d late resumes want 0", resume_bad - r0); end
    endtask

    task automatic test_reset_mid();
        int wb, lb;
        rand_msg(60);
        send(1'b0, 1'b0, 7, 0, wb, lb);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({message_word_in, message_word_addr, write_enable_in, block_valid, block_last, s_ready} !== 40'h0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", {message_word_in, message_word_addr, write_enable_in, block_valid, block_last, s_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        send(1'b0, 1'b0, 1000, 1, wb, lb);
        checks++;
        if (wr_q.size() - wb !== 16) begin errors++; $display("FAIL midreset_count got %0d want 16", wr_q.size() - wb); end
        for (int i = 0; i < exp_w.size() && wb + i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[wb+i] !== {4'(i % 16), exp_w[i]}) begin
                errors++; $display("FAIL midreset_word[%0d] got %h want %h", i, wr_q[wb+i], {4'(i % 16), exp_w[i]});
            end
        end
    endtask

    task automatic test_random();
        int wb, lb;
        for (int t = 0; t < 8; t++) begin
            rand_msg($urandom_range(0, 140));
            send(1'($urandom_range(0, 1)), 1'b1, 1000, $urandom_range(0, 4), wb, lb);
            checks++;
            if (wr_q.size() - wb !== exp_w.size()) begin
                errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, wr_q.size() - wb, exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && wb + i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[wb+i] !== {4'(i % 16), exp_w[i]}) begin
                    errors++; $display("FAIL rnd%0d_word[%0d] got %h want %h", t, i, wr_q[wb+i], {4'(i % 16), exp_w[i]});
                end
            end
            for (int b = 0; b < exp_blocks && lb + b < last_q.size(); b++) begin
                checks++;
                if (last_q[lb+b] !== (b == exp_blocks - 1)) begin
                    errors++; $display("FAIL rnd%0d_last[%0d] got %b want %b", t, b, last_q[lb+b], (b == exp_blocks - 1));
                end
            end
        end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL protocol_total got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_56_bytes();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
